sample_burst_framer: RTL

Collects qualified IQ samples from the four-channel sample filter into per-channel bursts and serialises complete bursts onto one 32-bit valid/ready stream. Each frame is a header word followed by one word per sample. Bursts are admitted whole or dropped whole, never truncated. Sits directly downstream of the sample filter and feeds the uplink packetiser.

---
 rtl/sample_burst_framer_pkg.sv | 42 ++++
 rtl/sample_burst_framer_chan.sv | 168 ++++++++++++++++
 rtl/sample_burst_framer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/sample_burst_framer_pkg.sv
// Shared constants, header layout and state encodings for the sample burst framer.
package sample_burst_pkg;

    localparam int unsigned NUM_CHAN = 4;
    localparam int unsigned SAMPLE_W = 24;
    localparam int unsigned LEN_W    = 8;

    localparam logic [7:0]  HDR_MAGIC     = 8'hA5;
    localparam int unsigned HDR_MAGIC_LSB = 24;
    localparam int unsigned HDR_CHAN_LSB  = 22;
    localparam int unsigned HDR_CHAN_W    = 2;
    localparam int unsigned HDR_SEQ_LSB   = 16;
    localparam int unsigned HDR_SEQ_W     = 6;
    localparam int unsigned HDR_LEN_LSB   = 0;

    typedef enum logic [1:0] {
        TRK_IDLE,
        TRK_OPEN,
        TRK_DROP
    } trk_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_HEAD,
        OUT_BODY
    } out_state_t;

    function automatic logic [31:0] make_header(
        input logic [HDR_CHAN_W-1:0] ch,
        input logic [HDR_SEQ_W-1:0]  seq,
        input logic [LEN_W-1:0]      len
    );
        logic [31:0] h;
        h = '0;
        h[HDR_MAGIC_LSB +: 8]         = HDR_MAGIC;
        h[HDR_CHAN_LSB +: HDR_CHAN_W] = ch;
        h[HDR_SEQ_LSB +: HDR_SEQ_W]   = seq;
        h[HDR_LEN_LSB +: LEN_W]       = len;
        return h;
    endfunction

endpackage

// File: rtl/sample_burst_framer_chan.sv
// One channel: burst tracker, sample FIFO, closed-burst length queue and free-space count.
module sample_burst_chan
    import sample_burst_pkg::*;
#(
    parameter int unsigned MAX_BURST  = 64,
    parameter int unsigned FIFO_DEPTH = 256,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned LEN_DEPTH  = 4
) (
    input  logic                data_clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_sample,
    input  logic                rd_pop,
    input  logic                len_pop,
    output logic [SAMPLE_W-1:0] rd_sample,
    output logic                len_avail,
    output logic [LEN_W-1:0]    len_head,
    output logic                overflow
);

    localparam int unsigned FAW = $clog2(FIFO_DEPTH);
    localparam int unsigned FCW = FAW + 1;
    localparam int unsigned LAW = (LEN_DEPTH > 1) ? $clog2(LEN_DEPTH) : 1;
    localparam int unsigned LCW = LAW + 1;
    localparam int unsigned GW  = $clog2(GAP_CYCLES + 1);

    localparam logic [LEN_W-1:0] MAX_L8   = LEN_W'(MAX_BURST);
    localparam logic [FCW-1:0]   MAX_LF   = FCW'(MAX_BURST);
    localparam logic [FCW-1:0]   DEPTH_LF = FCW'(FIFO_DEPTH);
    localparam logic [LCW-1:0]   LDEPTH_L = LCW'(LEN_DEPTH);
    localparam logic [LAW-1:0]   LLAST    = LAW'(LEN_DEPTH - 1);
    localparam logic [GW-1:0]    GAP_L    = GW'(GAP_CYCLES);

    trk_state_t         trk_q, trk_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [GW-1:0]      gap_q, gap_d, gap_inc;
    logic               wr_en, ovf_set, admit;
    logic               push_d, push_q;
    logic [LEN_W-1:0]   push_len_d, push_len_q;

    logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [FAW-1:0]      wr_ptr, rd_ptr;
    logic [FCW-1:0]      fifo_cnt, fifo_free;

    logic [LEN_W-1:0]    lq [LEN_DEPTH];
    logic [LAW-1:0]      lq_wr, lq_rd;
    logic [LCW-1:0]      lq_cnt;

    assign fifo_free = DEPTH_LF - fifo_cnt;
    // A closed burst still waiting to be pushed already owns a queue slot.
    assign admit     = (fifo_free >= MAX_LF) && ((lq_cnt + LCW'(push_q)) < LDEPTH_L);
    assign cnt_inc   = cnt_q + 1'b1;
    assign gap_inc   = gap_q + 1'b1;

    always_comb begin
        trk_d      = trk_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        wr_en      = 1'b0;
        push_d     = 1'b0;
        push_len_d = cnt_q;
        ovf_set    = 1'b0;
        case (trk_q)
            TRK_IDLE: begin
                if (in_valid) begin
                    cnt_d = 8'd1;
                    gap_d = '0;
                    if (admit) begin
                        trk_d = TRK_OPEN;
                        wr_en = 1'b1;
                    end else begin
                        trk_d   = TRK_DROP;
                        ovf_set = 1'b1;
                    end
                    if (MAX_BURST == 1) begin
                        trk_d      = TRK_IDLE;
                        push_d     = admit;
                        push_len_d = 8'd1;
                    end
                end
            end
            TRK_OPEN, TRK_DROP: begin
                if (in_valid) begin
                    wr_en = (trk_q == TRK_OPEN);
                    cnt_d = cnt_inc;
                    gap_d = '0;
                    if (cnt_inc == MAX_L8) begin
                        trk_d      = TRK_IDLE;
                        push_d     = (trk_q == TRK_OPEN);
                        push_len_d = cnt_inc;
                    end
                end else begin
                    gap_d = gap_inc;
                    if (gap_inc == GAP_L) begin
                        trk_d  = TRK_IDLE;
                        push_d = (trk_q == TRK_OPEN);
                    end
                end
            end
            default: trk_d = TRK_IDLE;
        endcase
    end

    always_ff @(posedge data_clk or posedge rst) begin
        if (rst) begin
            trk_q      <= TRK_IDLE;
            cnt_q      <= '0;
            gap_q      <= '0;
            push_q     <= 1'b0;
            push_len_q <= '0;
            overflow   <= 1'b0;
        end else begin
            trk_q      <= trk_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            push_q     <= push_d;
            push_len_q <= push_len_d;
            if (ovf_set) overflow <= 1'b1;
        end
    end

    always_ff @(posedge data_clk) begin
        if (wr_en) mem[wr_ptr] <= in_sample;
    end

    always_ff @(posedge data_clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
            if (rd_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign rd_sample = mem[rd_ptr];

    always_ff @(posedge data_clk) begin
        if (push_q) lq[lq_wr] <= push_len_q;
    end

    always_ff @(posedge data_clk or posedge rst) begin
        if (rst) begin
            lq_wr  <= '0;
            lq_rd  <= '0;
            lq_cnt <= '0;
        end else begin
            if (push_q)  lq_wr <= (lq_wr == LLAST) ? '0 : lq_wr + 1'b1;
            if (len_pop) lq_rd <= (lq_rd == LLAST) ? '0 : lq_rd + 1'b1;
            case ({push_q, len_pop})
                2'b10:   lq_cnt <= lq_cnt + 1'b1;
                2'b01:   lq_cnt <= lq_cnt - 1'b1;
                default: lq_cnt <= lq_cnt;
            endcase
        end
    end

    assign len_avail = (lq_cnt != '0);
    assign len_head  = lq[lq_rd];

endmodule

// File: rtl/sample_burst_framer.sv
// Four-channel IQ burst framer: per-channel burst capture, round-robin arbitration
// and header+sample serialisation onto a 32-bit valid/ready stream.
module sample_burst_framer
    import sample_burst_pkg::*;
#(
    parameter int unsigned MAX_BURST  = 64,
    parameter int unsigned FIFO_DEPTH = 256,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned LEN_DEPTH  = 4
) (
    input  logic        data_clk,
    input  logic        rst,
    input  logic [3:0]  din_valid,
    input  logic [95:0] data_iq,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_last,
    output logic [3:0]  overflow
);

    logic [SAMPLE_W-1:0] rd_sample [NUM_CHAN];
    logic [LEN_W-1:0]    len_head  [NUM_CHAN];
    logic [3:0]          len_avail;
    logic [3:0]          pop_sample, pop_len, seq_inc;

    for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
        sample_burst_chan #(
            .MAX_BURST  (MAX_BURST),
            .FIFO_DEPTH (FIFO_DEPTH),
            .GAP_CYCLES (GAP_CYCLES),
            .LEN_DEPTH  (LEN_DEPTH)
        ) u_chan (
            .data_clk  (data_clk),
            .rst       (rst),
            .in_valid  (din_valid[c]),
            .in_sample (data_iq[95-24*c -: 24]),
            .rd_pop    (pop_sample[c]),
            .len_pop   (pop_len[c]),
            .rd_sample (rd_sample[c]),
            .len_avail (len_avail[c]),
            .len_head  (len_head[c]),
            .overflow  (overflow[c])
        );
    end

    out_state_t       st_q, st_d;
    logic [1:0]       cur_q, cur_d, last_q, last_d;
    logic [LEN_W-1:0] len_q, len_d, wcnt_q, wcnt_d;
    logic [5:0]       seq_q [NUM_CHAN];
    logic [1:0]       grant, idx;
    logic             found;

    // Round-robin search begins one past the last channel granted.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NUM_CHAN; k++) begin
            idx = last_q + 2'(k);
            if (!found && len_avail[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    always_comb begin
        st_d       = st_q;
        cur_d      = cur_q;
        last_d     = last_q;
        len_d      = len_q;
        wcnt_d     = wcnt_q;
        pop_sample = '0;
        pop_len    = '0;
        seq_inc    = '0;
        case (st_q)
            OUT_IDLE: begin
                if (found) begin
                    st_d   = OUT_HEAD;
                    cur_d  = grant;
                    last_d = grant;
                    len_d  = len_head[grant];
                    wcnt_d = 8'd1;
                end
            end
            OUT_HEAD: begin
                if (m_ready) st_d = OUT_BODY;
            end
            OUT_BODY: begin
                if (m_ready) begin
                    pop_sample[cur_q] = 1'b1;
                    if (wcnt_q == len_q) begin
                        pop_len[cur_q] = 1'b1;
                        seq_inc[cur_q] = 1'b1;
                        st_d           = OUT_IDLE;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            default: st_d = OUT_IDLE;
        endcase
    end

    always_ff @(posedge data_clk or posedge rst) begin
        if (rst) begin
            st_q   <= OUT_IDLE;
            cur_q  <= '0;
            last_q <= 2'd3;
            len_q  <= '0;
            wcnt_q <= '0;
            for (int unsigned i = 0; i < NUM_CHAN; i++) seq_q[i] <= '0;
        end else begin
            st_q   <= st_d;
            cur_q  <= cur_d;
            last_q <= last_d;
            len_q  <= len_d;
            wcnt_q <= wcnt_d;
            for (int unsigned i = 0; i < NUM_CHAN; i++) begin
                if (seq_inc[i]) seq_q[i] <= seq_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        m_valid = (st_q != OUT_IDLE);
        m_last  = (st_q == OUT_BODY) && (wcnt_q == len_q);
        m_data  = '0;
        case (st_q)
            OUT_HEAD: m_data = make_header(cur_q, seq_q[cur_q], len_q);
            OUT_BODY: m_data = {8'h00, rd_sample[cur_q]};
            default:  m_data = '0;
        endcase
    end

endmodule
